uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_ctrl_edge_bit_counter.sv | 47 ++++
 rtl/uart_rx_ctrl.sv | 108 ++++++++++
 tb/tb_uart_rx_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// frame bit positions and the supported oversampling ratios.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_e;

   localparam int unsigned START_BIT     = 1;
   localparam int unsigned LAST_DATA_BIT = 9;
   localparam int unsigned PARITY_BIT    = 10;

   localparam int unsigned PRESCALE_8  = 8;
   localparam int unsigned PRESCALE_16 = 16;
   localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversample edge counter and frame bit counter. Both counters sit at zero
// whenever the controller is not inside a frame.
module edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      reload,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
   output logic                      bit_end
);

   localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE  = PRESCALE_WIDTH'(1);
   localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE   = BIT_CNT_WIDTH'(1);
   localparam logic [BIT_CNT_WIDTH-1:0]  BIT_FIRST = BIT_CNT_WIDTH'(START_BIT);

   // Not gated by enable so the FSM can use it without a combinational loop
   // through its next-state decode.
   assign bit_end = (edge_cnt == prescale - EDGE_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (reload) begin
         edge_cnt <= '0;
         bit_cnt  <= BIT_FIRST;
      end else if (enable) begin
         if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_ONE;
         end else begin
            edge_cnt <= edge_cnt + EDGE_ONE;
         end
      end else begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences start/data/parity/stop bits, drives the
// sampler, deserializer and checker enables, and flags accepted frames.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      PAR_EN,
   input  logic                      strt_glitch,
   input  logic                      par_err,
   input  logic                      stp_err,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
   output logic                      dat_samp_en,
   output logic                      deser_en,
   output logic                      strt_chk_en,
   output logic                      par_chk_en,
   output logic                      stp_chk_en,
   output logic                      data_valid,
   output logic                      busy
);

   rx_state_e                 state, next_state;
   logic [PRESCALE_WIDTH-1:0] prescale_lat;
   logic                      par_en_lat;
   logic                      frame_err;
   logic                      reload;
   logic                      count_en;
   logic                      bit_end_raw;
   logic                      bit_end;
   logic                      in_frame;

   assign in_frame = (state inside {START, DATA, PARITY, STOP});
   assign reload   = (state inside {IDLE, DONE}) && !RX_IN;
   assign count_en = (next_state inside {START, DATA, PARITY, STOP});
   assign bit_end  = bit_end_raw && in_frame;

   edge_bit_counter #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
   ) u_counter (
      .clk      (CLK),
      .rst_n    (RST),
      .enable   (count_en),
      .reload   (reload),
      .prescale (prescale_lat),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .bit_end  (bit_end_raw)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Frame settings are captured when a frame begins so the line can be
   // reconfigured mid-frame; the error flag is sticky until the next start.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         prescale_lat <= PRESCALE_WIDTH'(PRESCALE_8);
         par_en_lat   <= 1'b0;
         frame_err    <= 1'b0;
      end else if (reload) begin
         prescale_lat <= prescale;
         par_en_lat   <= PAR_EN;
         frame_err    <= 1'b0;
      end else if (bit_end && ((state == PARITY && par_err) || (state == STOP && stp_err))) begin
         frame_err <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (!RX_IN) next_state = START;
         START:  if (bit_end) next_state = strt_glitch ? IDLE : DATA;
         DATA: begin
            if (bit_end && bit_cnt == BIT_CNT_WIDTH'(LAST_DATA_BIT)) begin
               next_state = par_en_lat ? PARITY : STOP;
            end
         end
         PARITY: if (bit_end) next_state = STOP;
         STOP:   if (bit_end) next_state = DONE;
         DONE:   next_state = RX_IN ? IDLE : START;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      dat_samp_en = in_frame;
      deser_en    = (state == DATA);
      strt_chk_en = (state == START);
      par_chk_en  = (state == PARITY);
      stp_chk_en  = (state == STOP);
      data_valid  = (state == DONE) && !frame_err;
      busy        = (state != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frame table, hand-written corner sequences
// and random traffic, all compared every cycle against a frame-timeline model.
module tb_uart_rx_ctrl;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic [5:0] prescale;
   logic       PAR_EN;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       par_chk_en;
   logic       stp_chk_en;
   logic       data_valid;
   logic       busy;

   logic [16:0] out_vec;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: position within the frame timeline, not FSM states.
   int m_mode = 0;
   int m_k    = 0;
   int m_p    = 8;
   bit m_par  = 0;
   bit m_err  = 0;

   typedef struct {
      string      name;
      int         presc;
      bit         par;
      bit         glitch;
      bit         perr;
      bit         serr;
      logic [7:0] data;
      int         exp_strt;
      int         exp_deser;
      int         exp_par;
      int         exp_stp;
      int         exp_busy;
      int         exp_dv;
   } vec_t;

   vec_t vecs[6];

   uart_rx_ctrl #(
      .PRESCALE_WIDTH (6),
      .BIT_CNT_WIDTH  (4)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .prescale    (prescale),
      .PAR_EN      (PAR_EN),
      .strt_glitch (strt_glitch),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .dat_samp_en (dat_samp_en),
      .deser_en    (deser_en),
      .strt_chk_en (strt_chk_en),
      .par_chk_en  (par_chk_en),
      .stp_chk_en  (stp_chk_en),
      .data_valid  (data_valid),
      .busy        (busy)
   );

   assign out_vec = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                     par_chk_en, stp_chk_en, data_valid, busy};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, $time, actual, actual, expected, expected);
      end
   endtask

   task automatic applyStimulus(input logic rx, input int p, input logic par,
                                input logic g, input logic pe, input logic se);
      RX_IN       = rx;
      prescale    = 6'(p);
      PAR_EN      = par;
      strt_glitch = g;
      par_err     = pe;
      stp_err     = se;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic line_bit(input logic [7:0] d, input bit par, input int k, input int p);
      int i;
      i = k / p;
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (i == 9 && par) return ^d;
      return 1'b1;
   endfunction

   function automatic logic [16:0] model_expect();
      logic [5:0] e;
      logic [3:0] b;
      logic samp, deser, strt, parc, stpc, dv, bsy;
      int bitn;
      e = '0; b = '0;
      samp = 0; deser = 0; strt = 0; parc = 0; stpc = 0; dv = 0; bsy = 0;
      if (m_mode == 1) begin
         bitn  = m_k / m_p + 1;
         e     = 6'(m_k % m_p);
         b     = 4'(bitn);
         samp  = 1;
         bsy   = 1;
         strt  = (bitn == 1);
         deser = (bitn >= 2 && bitn <= 9);
         parc  = m_par && bitn == 10;
         stpc  = (bitn == (m_par ? 11 : 10));
      end else if (m_mode == 2) begin
         bsy = 1;
         dv  = !m_err;
      end
      return {e, b, samp, deser, strt, parc, stpc, dv, bsy};
   endfunction

   task automatic model_advance(input logic rx, input int p_in, input logic par_in,
                                input logic g, input logic pe, input logic se);
      int nb, bitn;
      bit bend;
      if (m_mode != 1) begin
         if (!rx) begin
            m_mode = 1; m_k = 0; m_p = p_in; m_par = par_in; m_err = 0;
         end else begin
            m_mode = 0;
         end
         return;
      end
      nb   = m_par ? 11 : 10;
      bitn = m_k / m_p + 1;
      bend = ((m_k % m_p) == m_p - 1);
      if (bend && bitn == 1 && g) begin
         m_mode = 0;
      end else if (bend && bitn == nb) begin
         if (se) m_err = 1;
         m_mode = 2;
      end else begin
         if (bend && m_par && bitn == 10 && pe) m_err = 1;
         m_k++;
      end
   endtask

   // Outputs are stable mid-cycle; the inputs seen here are the ones the
   // next rising edge will act on.
   always @(negedge CLK) begin
      if (!RST) begin
         checkOutput("model_cmp_reset", int'(out_vec), 0);
         m_mode = 0;
         m_err  = 0;
      end else begin
         checkOutput("model_cmp", int'(out_vec), int'(model_expect()));
         model_advance(RX_IN, int'(prescale), PAR_EN, strt_glitch, par_err, stp_err);
      end
   end

   // One frame from the table; prescale/PAR_EN inputs are scrambled after
   // the start edge to show the frame uses the captured settings.
   task automatic run_vector(input vec_t v);
      int nb, k, n_strt, n_deser, n_par, n_stp, n_busy, dv_cycle, n_dv;
      logic line;
      nb = v.par ? 11 : 10;
      n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_busy = 0; n_dv = 0;
      dv_cycle = -1;
      applyStimulus(1'b0, v.presc, v.par, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= nb * v.presc + 4; c++) begin
         tick();
         n_strt  += int'(strt_chk_en);
         n_deser += int'(deser_en);
         n_par   += int'(par_chk_en);
         n_stp   += int'(stp_chk_en);
         n_busy  += int'(busy);
         if (data_valid) begin
            n_dv++;
            if (dv_cycle < 0) dv_cycle = c;
         end
         k    = c - 1;
         line = line_bit(v.data, v.par, k, v.presc);
         if (v.glitch && k >= v.presc / 2) line = 1'b1;
         applyStimulus(line, (v.presc == 8) ? 16 : 8, !v.par,
                       v.glitch && k == v.presc - 1,
                       v.perr && v.par && k == 10 * v.presc - 1,
                       v.serr && k == nb * v.presc - 1);
      end
      checkOutput({v.name, "_strt_cycles"},  n_strt,  v.exp_strt);
      checkOutput({v.name, "_deser_cycles"}, n_deser, v.exp_deser);
      checkOutput({v.name, "_par_cycles"},   n_par,   v.exp_par);
      checkOutput({v.name, "_stp_cycles"},   n_stp,   v.exp_stp);
      checkOutput({v.name, "_busy_cycles"},  n_busy,  v.exp_busy);
      checkOutput({v.name, "_dv_cycle"},     dv_cycle, v.exp_dv);
      checkOutput({v.name, "_dv_pulses"},    n_dv,    (v.exp_dv >= 0) ? 1 : 0);
      checkOutput({v.name, "_idle_after"},   int'(busy), 0);
   endtask

   initial begin
      int         k, f, kk, gap, n_dv, p_rand;
      int         dv_q[$];
      logic       line;
      logic [7:0] d;

      vecs[0] = '{"a5_p8_nopar",   8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5,  8,  64,  0,  8,  81,  81};
      vecs[1] = '{"a5_p8_parerr",  8, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5,  8,  64,  8,  8,  89,  -1};
      vecs[2] = '{"glitch_p16",   16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16,   0,  0,  0,  16,  -1};
      vecs[3] = '{"stperr_p8",     8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A,  8,  64,  0,  8,  81,  -1};
      vecs[4] = '{"c3_p16_par",   16, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 16, 128, 16, 16, 177, 177};
      vecs[5] = '{"5a_p32_nopar", 32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 32, 256,  0, 32, 321, 321};

      RST = 1'b1;
      applyStimulus(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 RST = 1'b0;
      #1 checkOutput("reset_outputs", int'(out_vec), 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      tick();
      tick();

      for (int i = 0; i < 6; i++) begin
         run_vector(vecs[i]);
         tick();
      end

      // Back-to-back frames: the second start bit lands in the DONE cycle.
      gap = 0;
      applyStimulus(1'b0, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 2 * 321 + 4; c++) begin
         tick();
         if (data_valid) dv_q.push_back(c);
         if (c <= 642 && !busy) gap++;
         k  = c - 1;
         f  = k / 321;
         kk = k % 321;
         d  = (f == 0) ? 8'h3C : 8'hC3;
         if (f < 2 && kk < 320) begin
            applyStimulus(line_bit(d, 1'b0, kk, 32), 8, 1'b1, 1'b0, 1'b0, 1'b0);
         end else if (f == 0 && kk == 320) begin
            applyStimulus(1'b0, 32, 1'b0, 1'b0, 1'b0, 1'b0);
         end else begin
            applyStimulus(1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0);
         end
      end
      checkOutput("b2b_dv_pulses", dv_q.size(), 2);
      if (dv_q.size() == 2) begin
         checkOutput("b2b_first_dv", dv_q[0], 321);
         checkOutput("b2b_dv_spacing", dv_q[1] - dv_q[0], 321);
      end
      checkOutput("b2b_idle_gap", gap, 0);
      tick();

      // Reset asserted mid-frame at bit_cnt=5, edge_cnt=3.
      n_dv = 0;
      applyStimulus(1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (data_valid) n_dv++;
         applyStimulus(line_bit(8'h96, 1'b0, c - 1, 8), 8, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("pre_reset_bit_cnt", int'(bit_cnt), 5);
      checkOutput("pre_reset_edge_cnt", int'(edge_cnt), 3);
      RST = 1'b0;
      #1 checkOutput("reset_immediate", int'(out_vec), 0);
      applyStimulus(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         if (data_valid) n_dv++;
      end
      RST = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (data_valid) n_dv++;
      end
      checkOutput("reset_abort_no_dv", n_dv, 0);
      run_vector(vecs[0]);

      // Random traffic including an unsupported ratio (12).
      for (int n = 0; n < 4000; n++) begin
         tick();
         case ($urandom_range(0, 3))
            0:       p_rand = 8;
            1:       p_rand = 16;
            2:       p_rand = 32;
            default: p_rand = 12;
         endcase
         line = ($urandom_range(0, 24) != 0);
         applyStimulus(line, p_rand, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0));
      end

      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
